fir_queue_sequencer: RTL and testbench

//   Address/control sequencer for one band's 16-bit circular sample buffer (dual-port RAM) and its shared MAC.

---
 rtl/fir_queue_sequencer.sv | 80 ++++++++
 tb/tb_fir_queue_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_queue_sequencer.sv
// fir_queue_sequencer: write pointer, TAPS-long read window and MAC control for one band's circular sample buffer
// Ports: clk, rst_n (sync, active low); valid_rise (new sample this cycle);
//   we/wptr (RAM write); rptr/coeff_addr (RAM read and coefficient ROM addresses, aligned);
//   accum_clr/accum_en (MAC control); sequencing (pass reading buffer); smpl_valid (result ready);
//   full (FILL samples written); overrun (sticky: sample arrived during a pass)
module fir_queue_sequencer #(
  parameter int DEPTH = 1536,
  parameter int TAPS  = 1021,
  parameter int FILL  = 1531,
  parameter int AW    = 11,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_rise,
  output logic          we,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [CW-1:0] coeff_addr,
  output logic          accum_clr,
  output logic          accum_en,
  output logic          sequencing,
  output logic          smpl_valid,
  output logic          full,
  output logic          overrun
);
  localparam int NW = $clog2(FILL + 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] BACK   = AW'(TAPS - 1);
  localparam logic [AW-1:0] FWD    = AW'(DEPTH - TAPS + 1);
  localparam logic [CW-1:0] CLAST  = CW'(TAPS - 1);
  localparam logic [NW-1:0] FILL_N = NW'(FILL);
  typedef enum logic [1:0] {IDLE, SEQ, DONE} state_t;
  state_t state, state_nx;
  logic [NW-1:0] count;
  logic [AW-1:0] start;
  logic trig;
  assign we         = valid_rise;
  assign full       = count == FILL_N;
  assign sequencing = state == SEQ;
  assign trig       = valid_rise && full && state == IDLE;
  // window of TAPS samples ending at the one being written now; add instead of subtract when it would go negative
  assign start      = wptr >= BACK ? wptr - BACK : wptr + FWD;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (trig ? SEQ : IDLE) :
               state == SEQ  ? (coeff_addr == CLAST ? DONE : SEQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      coeff_addr <= '0;
      count      <= '0;
      accum_clr  <= 1'b0;
      accum_en   <= 1'b0;
      smpl_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (valid_rise) wptr <= wptr == LAST ? '0 : wptr + 1'b1;
      if (valid_rise && !full) count <= count + 1'b1;
      if (valid_rise && state != IDLE) overrun <= 1'b1;
      accum_clr  <= trig;
      // RAM read data lags rptr by one cycle, so the MAC enable lags the read window
      accum_en   <= sequencing;
      smpl_valid <= state == DONE;
      if (trig) begin
        rptr       <= start;
        coeff_addr <= '0;
      end else if (sequencing && coeff_addr != CLAST) begin
        rptr       <= rptr == LAST ? '0 : rptr + 1'b1;
        coeff_addr <= coeff_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_queue_sequencer.sv
// tb_fir_queue_sequencer: randomized scenario bench with a RAM/MAC environment and a sample-history model
module tb_fir_queue_sequencer;
  localparam int DEPTH = 1536, TAPS = 1021, FILL = 1531, AW = 11, CW = 10;
  logic clk = 0, rst_n = 0, valid_rise = 0;
  logic [15:0] wdata = '0;
  logic we, accum_clr, accum_en, sequencing, smpl_valid, full, overrun;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] coeff_addr;
  fir_queue_sequencer #(.DEPTH(DEPTH), .TAPS(TAPS), .FILL(FILL), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_rise(valid_rise), .we(we), .wptr(wptr), .rptr(rptr),
    .coeff_addr(coeff_addr), .accum_clr(accum_clr), .accum_en(accum_en), .sequencing(sequencing),
    .smpl_valid(smpl_valid), .full(full), .overrun(overrun));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int exp_wptr = 0, nwr = 0, seq_seen = 0, sv_seen = 0;
  bit exp_ovr = 0;
  logic [15:0] hist[$];
  function automatic logic [15:0] coef(input int k);
    return 16'((k * 7 + 3) % 251);
  endfunction
  // buffer RAM, registered coefficient ROM and MAC driven purely by the DUT's control outputs
  logic [15:0] ram [DEPTH];
  logic [15:0] rdata, coef_q;
  logic [63:0] acc;
  always @(posedge clk) begin
    if (we) ram[wptr] <= wdata;
    rdata  <= ram[rptr];
    coef_q <= coef(int'(coeff_addr));
    if (accum_clr) acc <= '0;
    else if (accum_en) acc <= acc + 64'(rdata) * 64'(coef_q);
  end
  always @(posedge clk) begin
    if (sequencing === 1'b1) seq_seen++;
    if (smpl_valid === 1'b1) sv_seen++;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick(input bit v);
    valid_rise = v;
    wdata = 16'($urandom);
    if (v) begin
      hist.push_back(wdata);
      exp_wptr = (exp_wptr + 1) % DEPTH;
      nwr++;
    end
    #1;
    checks++;
    if (we !== v) begin failures++; $display("FAIL we: got %b expected %b", we, v); end
    @(posedge clk);
    @(negedge clk);
    valid_rise = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick(0);
    tick(0);
    rst_n = 1;
    hist.delete();
    exp_wptr = 0;
    nwr = 0;
    exp_ovr = 0;
  endtask
  task automatic run_pass(input int extra_at);
    int s, e_rp, e_ca;
    bit e_seq, e_clr, e_en, e_sv;
    logic [63:0] es;
    s = (exp_wptr + DEPTH - (TAPS - 1)) % DEPTH;
    tick(1);
    es = '0;
    for (int k = 0; k < TAPS; k++) es += 64'(hist[hist.size() - TAPS + k]) * 64'(coef(k));
    for (int k = 1; k <= TAPS + 2; k++) begin
      e_seq = k <= TAPS;
      e_ca  = k <= TAPS ? k - 1 : TAPS - 1;
      e_rp  = (s + e_ca) % DEPTH;
      e_clr = k == 1;
      e_en  = k >= 2 && k <= TAPS + 1;
      e_sv  = k == TAPS + 2;
      checks += 7;
      if (sequencing !== e_seq) begin failures++; $display("FAIL sequencing T+%0d: got %b expected %b", k, sequencing, e_seq); end
      if (rptr !== AW'(e_rp)) begin failures++; $display("FAIL rptr T+%0d: got %0d expected %0d", k, rptr, e_rp); end
      if (coeff_addr !== CW'(e_ca)) begin failures++; $display("FAIL coeff_addr T+%0d: got %0d expected %0d", k, coeff_addr, e_ca); end
      if (accum_clr !== e_clr) begin failures++; $display("FAIL accum_clr T+%0d: got %b expected %b", k, accum_clr, e_clr); end
      if (accum_en !== e_en) begin failures++; $display("FAIL accum_en T+%0d: got %b expected %b", k, accum_en, e_en); end
      if (smpl_valid !== e_sv) begin failures++; $display("FAIL smpl_valid T+%0d: got %b expected %b", k, smpl_valid, e_sv); end
      if (wptr !== AW'(exp_wptr)) begin failures++; $display("FAIL wptr T+%0d: got %0d expected %0d", k, wptr, exp_wptr); end
      if (k == TAPS + 2) begin
        checks += 3;
        if (acc !== es) begin failures++; $display("FAIL filter_sum: got %0d expected %0d", acc, es); end
        if (overrun !== exp_ovr) begin failures++; $display("FAIL overrun: got %b expected %b", overrun, exp_ovr); end
        if (full !== 1'b1) begin failures++; $display("FAIL full_in_pass: got %b expected 1", full); end
      end else begin
        if (k == extra_at) exp_ovr = 1;
        tick(k == extra_at);
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks += 9;
    if (wptr !== '0) begin failures++; $display("FAIL reset_wptr: got %0d expected 0", wptr); end
    if (rptr !== '0) begin failures++; $display("FAIL reset_rptr: got %0d expected 0", rptr); end
    if (coeff_addr !== '0) begin failures++; $display("FAIL reset_coeff: got %0d expected 0", coeff_addr); end
    if (accum_clr !== 1'b0) begin failures++; $display("FAIL reset_clr: got %b expected 0", accum_clr); end
    if (accum_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", accum_en); end
    if (sequencing !== 1'b0) begin failures++; $display("FAIL reset_seq: got %b expected 0", sequencing); end
    if (smpl_valid !== 1'b0) begin failures++; $display("FAIL reset_sv: got %b expected 0", smpl_valid); end
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask
  task automatic test_fill();
    do_reset();
    seq_seen = 0;
    sv_seen = 0;
    for (int i = 0; i < FILL; i++) begin
      repeat ($urandom_range(0, 3)) tick(0);
      if (i == FILL - 1) begin
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL full_early: got %b expected 0", full); end
      end
      tick(1);
    end
    tick(0);
    checks += 5;
    if (wptr !== AW'(FILL)) begin failures++; $display("FAIL fill_wptr: got %0d expected %0d", wptr, FILL); end
    if (full !== (nwr >= FILL)) begin failures++; $display("FAIL fill_full: got %b expected %b", full, nwr >= FILL); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL fill_overrun: got %b expected 0", overrun); end
    if (seq_seen != 0) begin failures++; $display("FAIL fill_seq: got %0d cycles expected 0", seq_seen); end
    if (sv_seen != 0) begin failures++; $display("FAIL fill_sv: got %0d pulses expected 0", sv_seen); end
  endtask
  task automatic test_first_pass();
    run_pass(0);
  endtask
  task automatic test_overrun();
    tick(0);
    run_pass(500);
    tick(0);
    seq_seen = 0;
    sv_seen = 0;
    repeat (40) tick(0);
    checks += 3;
    if (seq_seen != 0) begin failures++; $display("FAIL overrun_no_second_pass: got %0d cycles expected 0", seq_seen); end
    if (sv_seen != 0) begin failures++; $display("FAIL overrun_extra_sv: got %0d pulses expected 0", sv_seen); end
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask
  task automatic test_reset_mid_pass();
    tick(1);
    repeat (299) tick(0);
    rst_n = 0;
    tick(0);
    checks += 5;
    if (sequencing !== 1'b0) begin failures++; $display("FAIL midreset_seq: got %b expected 0", sequencing); end
    if (accum_en !== 1'b0) begin failures++; $display("FAIL midreset_en: got %b expected 0", accum_en); end
    if (full !== 1'b0) begin failures++; $display("FAIL midreset_full: got %b expected 0", full); end
    if (wptr !== '0) begin failures++; $display("FAIL midreset_wptr: got %0d expected 0", wptr); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
    rst_n = 1;
    hist.delete();
    exp_wptr = 0;
    nwr = 0;
    exp_ovr = 0;
    seq_seen = 0;
    sv_seen = 0;
    repeat (1100) tick(0);
    checks += 2;
    if (sv_seen != 0) begin failures++; $display("FAIL midreset_sv: got %0d pulses expected 0", sv_seen); end
    if (seq_seen != 0) begin failures++; $display("FAIL midreset_resume: got %0d cycles expected 0", seq_seen); end
  endtask
  task automatic test_back_to_back();
    repeat (5) run_pass(0);
    checks++;
    if (wptr !== '0) begin failures++; $display("FAIL wrap_wptr: got %0d expected 0", wptr); end
  endtask
  task automatic test_wrap_window();
    tick(0);
    run_pass(0);
  endtask
  task automatic test_wrap_sequence();
    while (exp_wptr != 5) begin
      repeat ($urandom_range(1, 4)) tick(0);
      run_pass(0);
    end
    tick(0);
    run_pass(0);
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_first_pass();
    test_overrun();
    test_reset_mid_pass();
    test_fill();
    test_back_to_back();
    test_wrap_window();
    test_wrap_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
